bomb_scheduler: RTL and testbench
=================================

Name: bomb_scheduler

Overview:
- Single owner of the 10x10 bomb map (2-bit state per cell, active cells x,y in 1..8, index 10*x+y).
- Arbitrates bomb-placement requests from players A and B, enforces a per-player live-bomb limit and generates the 1 Hz game tick from the system clock.
- On each tick, runs a 64-cycle scan that advances every bomb through its states. For every exploding cell it emits one explosion strobe to the damage/health logic.

Parameters:
- TICK_DIV, 100000000, clk cycles per game tick; must be >= 128.
- MAX_BOMBS, 2, maximum live bombs per player.
- CNT_W, 2, width of the per-player live-bomb counters; must hold MAX_BOMBS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i_placeA  in  1  one-cycle place request, player A (already debounced)
- i_placeB  in  1  one-cycle place request, player B
- playerAx, playerAy, playerBx, playerBy  in  4 each  player coordinates
- game_state  in  2  0 = running; nonzero = game over (freeze)
- o_bombMap_0  out  100  bit 0 of each cell state
- o_bombMap_1  out  100  bit 1 of each cell state
- o_expl_valid  out  1  one-cycle strobe: the cell at o_expl_x/o_expl_y exploded
- o_expl_x, o_expl_y  out  4 each  coordinates of the exploding cell
- o_expl_owner  out  1  owner of the exploding bomb: 0 = A, 1 = B
- o_placedA, o_placedB  out  1 each  one-cycle pulse on a successful placement
- o_countA, o_countB  out  CNT_W each  live-bomb count per player
- o_busy  out  1  high while the scan is running

Behaviour:
- Reset (rst low, async) clears:
  - map, owner bits, counters, pending flags, tick counter;
  - all strobes and o_busy;
  - round-robin priority to A; FSM to IDLE.
- Cell states: 0 none, 1 armed, 2 fuse, 3 exploding. Cells outside 1..8 always read 0.
- Tick generator:
  - counter runs 0..TICK_DIV-1 and asserts tick for one cycle at wrap;
  - counts only while game_state == 0, and holds its value otherwise.
- Request capture:
  - a request pulse sets pendingX and latches that player's coordinates on the same edge;
  - a new pulse while pendingX is set overwrites the latched coordinates.
- FSM IDLE:
  - If tick is asserted: go to SCAN. No placement is serviced in that cycle.
  - Otherwise, service at most one pending request per cycle.
  - When both players are pending, the priority holder wins and priority flips to the other player.
  - A single pending request is serviced without changing priority.
- Placement rules:
  - The placement is granted only if x,y are in 1..8, the cell state is 0, and countX < MAX_BOMBS.
  - On grant: cell <= 1, owner bit <= player, countX += 1, o_placedX pulses.
  - On failure: the request is dropped silently.
  - The serviced player's pending flag clears either way.
- Placement latency: request sampled on edge n, map and o_placedX updated on edge n+1 when uncontended.
- Both players on the same cell: the winner places; the loser is serviced on the next cycle and rejected because the cell is occupied.
- FSM SCAN:
  - Visits cells in order x=1..8 (outer), y=1..8 (inner), one cell per cycle, 64 cycles total; o_busy = 1.
  - State updates per cell: 0 stays 0; 1 becomes 2; 2 becomes 3.
  - State 3 becomes 0, and in the same cycle:
    - o_expl_valid pulses with x, y and the owner;
    - the owner's count decrements, saturating at 0.
  - After the last cell the FSM returns to IDLE. Pending requests captured during the scan are then serviced in IDLE.
- The FSM is written so that a tick during SCAN cannot occur (TICK_DIV >= 128).
- Freeze (game_state != 0):
  - request pulses are ignored and pending flags are cleared;
  - a scan already in progress completes;
  - no new scan starts and the map is otherwise held.
- Outputs are registered. o_bombMap bits at non-playable indices are constant 0.

Decomposition:
- Package bomb_pkg:
  - cell-state constants BOMB_NONE / BOMB_ARMED / BOMB_FUSE / BOMB_EXPLODE (0..3);
  - GRID_MIN = 1, GRID_MAX = 8, ROW_STRIDE = 10;
  - FSM state encodings IDLE / SCAN.
- Sub-module bomb_tick_gen: parameterised by TICK_DIV, with inputs clk, rst and enable, and a one-cycle tick output.
- Arbitration, counters, map storage and scan stay in bomb_scheduler.

Test Plan:
- Bench uses TICK_DIV=200.
- Reset mid-scan (rst low at scan cycle 30) -> map all 0, counts 0, o_busy 0 immediately. The first tick after release occurs 200 cycles later.
- Place at A(3,4):
  - i_placeA pulse -> after the next edge, cell 34 = 1, o_placedA pulse, o_countA = 1;
  - 3 ticks later: o_expl_valid with x=3, y=4, owner=0 during that scan; cell 34 = 0; o_countA = 0.
- Simultaneous contention: both request the same cell (5,5) with priority A -> A places. B is serviced next cycle and rejected (no o_placedB). Priority is now B. A repeat of the scenario on another cell -> B wins.
- Limit: A places at (1,1), then (1,2), then (1,3) with MAX_BOMBS=2 -> third request rejected, o_countA stays 2, cell 13 = 0.
- Request during SCAN: i_placeB at scan cycle 10 -> no map change until the scan ends; cell set on the edge after the FSM returns to IDLE. Out-of-range request at (0,5) or (9,2) -> rejected.
- Freeze: with game_state=2, request pulses and 1000 cycles produce no map change, no tick scan and no strobes.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared constants, FSM encoding and a grid helper for the bomb scheduler.
// Cell states are 2-bit codes; playable coordinates are 1..8 on a 10-wide map.
package bomb_pkg;

    localparam logic [1:0] BOMB_NONE    = 2'd0;
    localparam logic [1:0] BOMB_ARMED   = 2'd1;
    localparam logic [1:0] BOMB_FUSE    = 2'd2;
    localparam logic [1:0] BOMB_EXPLODE = 2'd3;

    localparam int GRID_MIN   = 1;
    localparam int GRID_MAX   = 8;
    localparam int ROW_STRIDE = 10;
    localparam int GRID_CELLS = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } sched_state_e;

    function automatic logic in_grid(input logic [3:0] v);
        return (int'(v) >= GRID_MIN) && (int'(v) <= GRID_MAX);
    endfunction

endpackage

// File: rtl/bomb_scheduler_if.sv
// Player request / map output bundle between the scheduler and the rest of the game.
interface bomb_scheduler_if #(
    parameter int CNT_W = 2
);
    import bomb_pkg::*;

    // Requests are fire-and-forget one-cycle pulses with no ready: the scheduler
    // always captures them, and acceptance is reported only by o_placedA/o_placedB.
    logic             i_placeA;
    logic             i_placeB;
    logic [3:0]       playerAx;
    logic [3:0]       playerAy;
    logic [3:0]       playerBx;
    logic [3:0]       playerBy;
    logic [1:0]       game_state;

    logic [99:0]      o_bombMap_0;
    logic [99:0]      o_bombMap_1;
    logic             o_expl_valid;
    logic [3:0]       o_expl_x;
    logic [3:0]       o_expl_y;
    logic             o_expl_owner;
    logic             o_placedA;
    logic             o_placedB;
    logic [CNT_W-1:0] o_countA;
    logic [CNT_W-1:0] o_countB;
    logic             o_busy;
    sched_state_e     dbg_state;

    modport master (
        output i_placeA, i_placeB, playerAx, playerAy, playerBx, playerBy, game_state,
        input  o_bombMap_0, o_bombMap_1, o_expl_valid, o_expl_x, o_expl_y, o_expl_owner,
        input  o_placedA, o_placedB, o_countA, o_countB, o_busy, dbg_state
    );

    modport slave (
        input  i_placeA, i_placeB, playerAx, playerAy, playerBx, playerBy, game_state,
        output o_bombMap_0, o_bombMap_1, o_expl_valid, o_expl_x, o_expl_y, o_expl_owner,
        output o_placedA, o_placedB, o_countA, o_countB, o_busy, dbg_state
    );

endinterface

// File: rtl/bomb_tick_gen.sv
// Game tick divider: one-cycle tick every TICK_DIV enabled cycles; holds while disabled.
module bomb_tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = enable && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bomb_scheduler.sv
// Owns the bomb map: arbitrates A/B placements, enforces the live-bomb limit and
// runs a 64-cycle aging scan on every game tick, strobing each explosion.
module bomb_scheduler
    import bomb_pkg::*;
#(
    parameter int TICK_DIV  = 100000000,
    parameter int MAX_BOMBS = 2,
    parameter int CNT_W     = 2
) (
    input logic             clk,
    input logic             rst,
    bomb_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BOMBS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    sched_state_e     state_q, state_d;
    logic [5:0]       scan_q, scan_d;
    logic [63:0][1:0] cell_q, cell_d;
    logic [63:0]      owner_q, owner_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic             pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic [3:0]       ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d;
    logic             prio_q, prio_d;
    logic             placed_a_q, placed_a_d, placed_b_q, placed_b_d;
    logic             expl_valid_q, expl_valid_d;
    logic             expl_owner_q, expl_owner_d;
    logic [3:0]       expl_x_q, expl_x_d, expl_y_q, expl_y_d;

    logic             tick;
    logic             running;
    logic             svc_a, svc_b, grant;
    logic [3:0]       req_x, req_y;
    logic [5:0]       req_idx;
    logic [CNT_W-1:0] req_cnt;
    logic [99:0]      map0, map1;

    assign running = (bus.game_state == 2'd0);

    bomb_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .enable(running),
        .tick  (tick)
    );

    always_comb begin
        state_d      = state_q;
        scan_d       = scan_q;
        cell_d       = cell_q;
        owner_d      = owner_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        pend_a_d     = pend_a_q;
        pend_b_d     = pend_b_q;
        ax_d         = ax_q;
        ay_d         = ay_q;
        bx_d         = bx_q;
        by_d         = by_q;
        prio_d       = prio_q;
        placed_a_d   = 1'b0;
        placed_b_d   = 1'b0;
        expl_valid_d = 1'b0;
        expl_x_d     = expl_x_q;
        expl_y_d     = expl_y_q;
        expl_owner_d = expl_owner_q;
        svc_a        = 1'b0;
        svc_b        = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick pre-empts placement for this cycle; pending requests wait.
                if (tick) begin
                    state_d = SCAN;
                    scan_d  = '0;
                end else if (running) begin
                    if (pend_a_q && pend_b_q) begin
                        svc_a  = ~prio_q;
                        svc_b  = prio_q;
                        prio_d = ~prio_q;
                    end else begin
                        svc_a = pend_a_q;
                        svc_b = pend_b_q;
                    end
                end
            end
            SCAN: begin
                case (cell_q[scan_q])
                    BOMB_ARMED: cell_d[scan_q] = BOMB_FUSE;
                    BOMB_FUSE:  cell_d[scan_q] = BOMB_EXPLODE;
                    BOMB_EXPLODE: begin
                        cell_d[scan_q] = BOMB_NONE;
                        expl_valid_d   = 1'b1;
                        expl_x_d       = {1'b0, scan_q[5:3]} + 4'd1;
                        expl_y_d       = {1'b0, scan_q[2:0]} + 4'd1;
                        expl_owner_d   = owner_q[scan_q];
                        if (owner_q[scan_q]) begin
                            if (cnt_b_q != '0) cnt_b_d = cnt_b_q - CNT_ONE;
                        end else begin
                            if (cnt_a_q != '0) cnt_a_d = cnt_a_q - CNT_ONE;
                        end
                    end
                    default: ;
                endcase
                if (scan_q == 6'd63) begin
                    state_d = IDLE;
                end else begin
                    scan_d = scan_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Placement for whichever player was serviced this cycle (at most one).
        req_x   = svc_b ? bx_q : ax_q;
        req_y   = svc_b ? by_q : ay_q;
        req_cnt = svc_b ? cnt_b_q : cnt_a_q;
        req_idx = {req_x[2:0] - 3'd1, req_y[2:0] - 3'd1};
        grant   = (svc_a || svc_b) && in_grid(req_x) && in_grid(req_y) &&
                  (cell_q[req_idx] == BOMB_NONE) && (req_cnt < MAX_CNT);

        if (svc_a) pend_a_d = 1'b0;
        if (svc_b) pend_b_d = 1'b0;
        if (grant) begin
            cell_d[req_idx]  = BOMB_ARMED;
            owner_d[req_idx] = svc_b;
            if (svc_b) begin
                cnt_b_d    = cnt_b_q + CNT_ONE;
                placed_b_d = 1'b1;
            end else begin
                cnt_a_d    = cnt_a_q + CNT_ONE;
                placed_a_d = 1'b1;
            end
        end

        // A fresh pulse wins over a service clear on the same edge.
        if (!running) begin
            pend_a_d = 1'b0;
            pend_b_d = 1'b0;
        end else begin
            if (bus.i_placeA) begin
                pend_a_d = 1'b1;
                ax_d     = bus.playerAx;
                ay_d     = bus.playerAy;
            end
            if (bus.i_placeB) begin
                pend_b_d = 1'b1;
                bx_d     = bus.playerBx;
                by_d     = bus.playerBy;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            scan_q       <= '0;
            cell_q       <= '0;
            owner_q      <= '0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            pend_a_q     <= 1'b0;
            pend_b_q     <= 1'b0;
            ax_q         <= '0;
            ay_q         <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            prio_q       <= 1'b0;
            placed_a_q   <= 1'b0;
            placed_b_q   <= 1'b0;
            expl_valid_q <= 1'b0;
            expl_x_q     <= '0;
            expl_y_q     <= '0;
            expl_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_q       <= scan_d;
            cell_q       <= cell_d;
            owner_q      <= owner_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            ax_q         <= ax_d;
            ay_q         <= ay_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            prio_q       <= prio_d;
            placed_a_q   <= placed_a_d;
            placed_b_q   <= placed_b_d;
            expl_valid_q <= expl_valid_d;
            expl_x_q     <= expl_x_d;
            expl_y_q     <= expl_y_d;
            expl_owner_q <= expl_owner_d;
        end
    end

    // Scatter the 64 stored cells onto the 10x10 map; border cells stay 0.
    always_comb begin
        map0 = '0;
        map1 = '0;
        for (int x = GRID_MIN; x <= GRID_MAX; x++) begin
            for (int y = GRID_MIN; y <= GRID_MAX; y++) begin
                map0[ROW_STRIDE*x + y] = cell_q[(x-1)*8 + (y-1)][0];
                map1[ROW_STRIDE*x + y] = cell_q[(x-1)*8 + (y-1)][1];
            end
        end
    end

    assign bus.o_bombMap_0  = map0;
    assign bus.o_bombMap_1  = map1;
    assign bus.o_expl_valid = expl_valid_q;
    assign bus.o_expl_x     = expl_x_q;
    assign bus.o_expl_y     = expl_y_q;
    assign bus.o_expl_owner = expl_owner_q;
    assign bus.o_placedA    = placed_a_q;
    assign bus.o_placedB    = placed_b_q;
    assign bus.o_countA     = cnt_a_q;
    assign bus.o_countB     = cnt_b_q;
    assign bus.o_busy       = (state_q == SCAN);
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Randomised and directed bench for bomb_scheduler against a grid-level game model.
module tb_bomb_scheduler;

    localparam int TICK_DIV  = 200;
    localparam int MAX_BOMBS = 2;
    localparam int CNT_W     = 2;

    logic clk;
    logic rst;

    bomb_scheduler_if #(.CNT_W(CNT_W)) bus ();

    bomb_scheduler #(
        .TICK_DIV (TICK_DIV),
        .MAX_BOMBS(MAX_BOMBS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [99:0] obs, input logic [99:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- game model ----------------
    int m_map[10][10];
    bit m_own[10][10];
    int m_cnt_a, m_cnt_b;
    bit m_pend_a, m_pend_b;
    int m_ax, m_ay, m_bx, m_by;
    bit m_prio;
    int m_tcnt;
    int m_scan;
    bit m_placed_a, m_placed_b, m_ev;

    task automatic model_reset();
        for (int x = 0; x < 10; x++)
            for (int y = 0; y < 10; y++) begin
                m_map[x][y] = 0;
                m_own[x][y] = 1'b0;
            end
        m_cnt_a = 0; m_cnt_b = 0;
        m_pend_a = 0; m_pend_b = 0;
        m_ax = 0; m_ay = 0; m_bx = 0; m_by = 0;
        m_prio = 0; m_tcnt = 0; m_scan = -1;
        m_placed_a = 0; m_placed_b = 0; m_ev = 0;
        exp_q.delete();
    endtask

    task automatic model_place(input bit who, input int x, input int y);
        int c;
        c = who ? m_cnt_b : m_cnt_a;
        if (x >= 1 && x <= 8 && y >= 1 && y <= 8 && c < MAX_BOMBS) begin
            if (m_map[x][y] == 0) begin
                m_map[x][y] = 1;
                m_own[x][y] = who;
                if (who) begin m_cnt_b++; m_placed_b = 1; end
                else     begin m_cnt_a++; m_placed_a = 1; end
            end
        end
    endtask

    task automatic model_step();
        bit run, tick, who;
        int x, y;
        m_placed_a = 0; m_placed_b = 0; m_ev = 0;
        run  = (bus.game_state == 2'd0);
        tick = run && (m_tcnt == TICK_DIV - 1);
        if (run) m_tcnt = (m_tcnt + 1) % TICK_DIV;
        if (m_scan >= 0) begin
            x = m_scan / 8 + 1;
            y = m_scan % 8 + 1;
            if (m_map[x][y] == 3) begin
                m_map[x][y] = 0;
                m_ev = 1;
                exp_q.push_back({m_own[x][y], 4'(x), 4'(y)});
                if (m_own[x][y]) m_cnt_b = (m_cnt_b > 0) ? m_cnt_b - 1 : 0;
                else             m_cnt_a = (m_cnt_a > 0) ? m_cnt_a - 1 : 0;
            end else if (m_map[x][y] != 0) begin
                m_map[x][y] = m_map[x][y] + 1;
            end
            m_scan = (m_scan == 63) ? -1 : m_scan + 1;
        end else if (tick) begin
            m_scan = 0;
        end else if (run && (m_pend_a || m_pend_b)) begin
            if (m_pend_a && m_pend_b) begin
                who = m_prio;
                m_prio = !m_prio;
            end else begin
                who = m_pend_b;
            end
            if (who) begin model_place(1'b1, m_bx, m_by); m_pend_b = 0; end
            else     begin model_place(1'b0, m_ax, m_ay); m_pend_a = 0; end
        end
        if (!run) begin
            m_pend_a = 0; m_pend_b = 0;
        end else begin
            if (bus.i_placeA) begin m_pend_a = 1; m_ax = bus.playerAx; m_ay = bus.playerAy; end
            if (bus.i_placeB) begin m_pend_b = 1; m_bx = bus.playerBx; m_by = bus.playerBy; end
        end
    endtask

    task automatic compare_all();
        logic [99:0] e0, e1;
        logic [8:0]  got;
        e0 = '0; e1 = '0;
        for (int x = 0; x < 10; x++)
            for (int y = 0; y < 10; y++) begin
                e0[10*x + y] = m_map[x][y][0];
                e1[10*x + y] = m_map[x][y][1];
            end
        check_eq("map_bit0", bus.o_bombMap_0, e0);
        check_eq("map_bit1", bus.o_bombMap_1, e1);
        check_eq("count_a", bus.o_countA, m_cnt_a);
        check_eq("count_b", bus.o_countB, m_cnt_b);
        check_eq("placed_a", bus.o_placedA, m_placed_a);
        check_eq("placed_b", bus.o_placedB, m_placed_b);
        check_eq("busy", bus.o_busy, m_scan >= 0);
        check_eq("expl_valid", bus.o_expl_valid, m_ev);
        if (bus.o_expl_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("expl_unexpected", bus.o_expl_valid, 1'b0);
            end else begin
                got = exp_q.pop_front();
                check_eq("expl_cell", {bus.o_expl_owner, bus.o_expl_x, bus.o_expl_y}, got);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        if (rst) model_step();
        else     model_reset();
        #1 compare_all();
    endtask

    task automatic pulse(input bit a, input bit b, input int ax, input int ay,
                         input int bx, input int by);
        bus.i_placeA = a;
        bus.i_placeB = b;
        bus.playerAx = 4'(ax);
        bus.playerAy = 4'(ay);
        bus.playerBx = 4'(bx);
        bus.playerBy = 4'(by);
        step();
        bus.i_placeA = 1'b0;
        bus.i_placeB = 1'b0;
    endtask

    task automatic rand_inputs();
        bus.i_placeA = ($urandom_range(0, 7) == 0);
        bus.i_placeB = ($urandom_range(0, 7) == 0);
        bus.playerAx = 4'($urandom_range(0, 9));
        bus.playerAy = 4'($urandom_range(0, 9));
        bus.playerBx = 4'($urandom_range(0, 9));
        bus.playerBy = 4'($urandom_range(0, 9));
    endtask

    function automatic logic [1:0] dut_cell(input int idx);
        return {bus.o_bombMap_1[idx], bus.o_bombMap_0[idx]};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int k;
        bit seen;
        logic [3:0] sx, sy;
        logic so;
        logic [99:0] snap0, snap1;
        int saw_busy, saw_ev, saw_placed;

        rst = 1'b1;
        bus.i_placeA = 1'b0; bus.i_placeB = 1'b0;
        bus.playerAx = '0; bus.playerAy = '0; bus.playerBx = '0; bus.playerBy = '0;
        bus.game_state = 2'd0;
        model_reset();
        #2 rst = 1'b0;
        #1 compare_all();
        repeat (3) step();
        check_eq("rst_busy", bus.o_busy, 1'b0);
        check_eq("rst_count_a", bus.o_countA, 2'd0);
        check_eq("rst_map0", bus.o_bombMap_0, '0);
        rst = 1'b1;

        // Single placement, then three ticks until it explodes.
        pulse(1, 0, 3, 4, 0, 0);
        step();
        check_eq("s1_cell34", dut_cell(34), 2'd1);
        check_eq("s1_placed_a", bus.o_placedA, 1'b1);
        check_eq("s1_count_a", bus.o_countA, 2'd1);
        seen = 1'b0; sx = '0; sy = '0; so = 1'b1;
        for (int i = 0; i < 700; i++) begin
            step();
            if (bus.o_expl_valid && !seen) begin
                seen = 1'b1; sx = bus.o_expl_x; sy = bus.o_expl_y; so = bus.o_expl_owner;
            end
        end
        check_eq("s1_expl_seen", seen, 1'b1);
        check_eq("s1_expl_x", sx, 4'd3);
        check_eq("s1_expl_y", sy, 4'd4);
        check_eq("s1_expl_owner", so, 1'b0);
        check_eq("s1_cell34_clear", dut_cell(34), 2'd0);
        check_eq("s1_count_a_zero", bus.o_countA, 2'd0);

        // Contention on one cell, twice, priority alternating.
        pulse(1, 1, 5, 5, 5, 5);
        step();
        check_eq("s2_a_wins", bus.o_placedA, 1'b1);
        check_eq("s2_b_waits", bus.o_placedB, 1'b0);
        check_eq("s2_cell55", dut_cell(55), 2'd1);
        step();
        check_eq("s2_b_rejected", bus.o_placedB, 1'b0);
        check_eq("s2_count_b", bus.o_countB, 2'd0);
        pulse(1, 1, 6, 6, 6, 6);
        step();
        check_eq("s2_b_wins", bus.o_placedB, 1'b1);
        check_eq("s2_a_waits", bus.o_placedA, 1'b0);
        check_eq("s2_cell66", dut_cell(66), 2'd1);
        step();
        check_eq("s2_a_rejected", bus.o_placedA, 1'b0);
        check_eq("s2_count_a", bus.o_countA, 2'd1);

        // Reset in the middle of a scan, then time the first tick.
        k = 0;
        while (!bus.o_busy && k < 400) begin step(); k++; end
        check_eq("s3_scan_started", bus.o_busy, 1'b1);
        repeat (30) step();
        rst = 1'b0;
        model_reset();
        #1 compare_all();
        check_eq("s3_rst_busy", bus.o_busy, 1'b0);
        check_eq("s3_rst_count_a", bus.o_countA, 2'd0);
        check_eq("s3_rst_count_b", bus.o_countB, 2'd0);
        check_eq("s3_rst_map1", bus.o_bombMap_1, '0);
        repeat (3) step();
        rst = 1'b1;
        k = 0;
        while (!bus.o_busy && k < 400) begin step(); k++; end
        check_eq("s3_first_tick_cycles", k, 200);

        // Request during scan is held until the scan ends.
        repeat (10) step();
        pulse(0, 1, 0, 0, 7, 7);
        k = 0;
        while (bus.o_busy && k < 100) begin
            check_eq("s4_hold_cell77", dut_cell(77), 2'd0);
            step();
            k++;
        end
        check_eq("s4_scan_done", bus.o_busy, 1'b0);
        check_eq("s4_cell77_before", dut_cell(77), 2'd0);
        step();
        check_eq("s4_cell77_after", dut_cell(77), 2'd1);
        check_eq("s4_placed_b", bus.o_placedB, 1'b1);

        // Live-bomb limit and out-of-range coordinates.
        pulse(1, 0, 1, 1, 0, 0); step();
        check_eq("s5_place11", bus.o_placedA, 1'b1);
        pulse(1, 0, 1, 2, 0, 0); step();
        check_eq("s5_place12", bus.o_placedA, 1'b1);
        pulse(1, 0, 1, 3, 0, 0); step();
        check_eq("s5_limit_reject", bus.o_placedA, 1'b0);
        check_eq("s5_limit_count", bus.o_countA, 2'd2);
        check_eq("s5_cell13", dut_cell(13), 2'd0);
        pulse(0, 1, 0, 0, 0, 5); step();
        check_eq("s5_reject_x0", bus.o_placedB, 1'b0);
        pulse(0, 1, 0, 0, 9, 2); step();
        check_eq("s5_reject_x9", bus.o_placedB, 1'b0);
        check_eq("s5_count_b", bus.o_countB, 2'd1);

        // Random traffic with occasional freeze windows.
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0)
                bus.game_state = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rand_inputs();
            step();
        end
        bus.i_placeA = 1'b0; bus.i_placeB = 1'b0; bus.game_state = 2'd0;

        // Freeze: nothing moves for 1000 cycles.
        k = 0;
        while (bus.o_busy && k < 100) begin step(); k++; end
        check_eq("s6_idle_before_freeze", bus.o_busy, 1'b0);
        bus.game_state = 2'd2;
        step();
        snap0 = bus.o_bombMap_0;
        snap1 = bus.o_bombMap_1;
        saw_busy = 0; saw_ev = 0; saw_placed = 0;
        for (int i = 0; i < 1000; i++) begin
            rand_inputs();
            step();
            if (bus.o_busy) saw_busy++;
            if (bus.o_expl_valid) saw_ev++;
            if (bus.o_placedA || bus.o_placedB) saw_placed++;
        end
        bus.i_placeA = 1'b0; bus.i_placeB = 1'b0;
        check_eq("s6_frozen_map0", bus.o_bombMap_0, snap0);
        check_eq("s6_frozen_map1", bus.o_bombMap_1, snap1);
        check_eq("s6_no_scan", saw_busy, 0);
        check_eq("s6_no_expl", saw_ev, 0);
        check_eq("s6_no_place", saw_placed, 0);

        check_eq("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
